// File: rtl/cc_fetch_queue_if.sv
// Fetch-queue bus: upstream push, decode-side valid/ready, and status back to fetch.
interface cc_fetch_queue_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             except;
    logic             in_en;
    logic [WIDTH-1:0] in_data;
    logic             fstall;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             overflow;

    // Queue side.
    modport slave (
        input  except, in_en, in_data, out_ready,
        output fstall, out_valid, out_data, count, overflow
    );

    // Pipeline / environment side.
    modport master (
        output except, in_en, in_data, out_ready,
        input  fstall, out_valid, out_data, count, overflow
    );
endinterface

// File: rtl/cc_fetch_queue.sv
// First-word-fall-through fetch queue with registered stall generation and
// headroom for the words the upstream stage can still release after stalling.
module cc_fetch_queue #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    cc_fetch_queue_if.slave    bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned STALL_AT = DEPTH - MARGIN;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    rp_q;
    logic [CW-1:0]    count_q;
    logic             fstall_q;
    logic             overflow_q;

    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic [CW-1:0]    count_d;
    logic [PW-1:0]    wp_d;
    logic [PW-1:0]    rp_d;
    logic             fstall_d;
    logic             overflow_d;

    // Handshake decode and next-state computation.
    always_comb begin
        pop_c      = 1'b0;
        push_c     = 1'b0;
        drop_c     = 1'b0;
        count_d    = count_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        fstall_d   = fstall_q;
        overflow_d = overflow_q;

        pop_c  = (count_q != CW'(0)) & bus.out_ready;
        push_c = bus.in_en & ((count_q < CW'(DEPTH)) | pop_c);
        drop_c = bus.in_en & ~push_c;

        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        wp_d       = wp_q + PW'(push_c);
        rp_d       = rp_q + PW'(pop_c);
        fstall_d   = (count_d >= CW'(STALL_AT));
        overflow_d = overflow_q | drop_c;
    end

    // State update: reset, then flush, then normal operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            fstall_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.except) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            fstall_q <= 1'b0;
        end else begin
            if (push_c) begin
                mem_q[wp_q] <= bus.in_data;
            end
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            fstall_q   <= fstall_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.fstall    = fstall_q;
    assign bus.overflow  = overflow_q;
    assign bus.count     = count_q;
    assign bus.out_valid = (count_q != CW'(0));
    assign bus.out_data  = mem_q[rp_q];
endmodule
